// File: rtl/pong_game.sv
// Per-frame pong game-state engine: paddles, ball, scores and serve/game-over sequencing.
// Define PONG_AI_EN to have the right paddle track the ball instead of following r_up/r_down.
module pong_game #(
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       l_up,
  input  logic       l_down,
  input  logic       r_up,
  input  logic       r_down,
  output logic [9:0] l_pos,
  output logic [9:0] r_pos,
  output logic [9:0] x_ball_pos,
  output logic [9:0] y_ball_pos,
  output logic [3:0] l_score,
  output logic [3:0] r_score,
  output logic       game_over
);

  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

  localparam logic [10:0] PSPEED     = 11'(PADDLE_SPEED);
  localparam logic [9:0]  PSPEED10   = 10'(PADDLE_SPEED);
  localparam logic [10:0] BSPEED     = 11'(BALL_SPEED);
  localparam logic [9:0]  BSPEED10   = 10'(BALL_SPEED);
  localparam logic [7:0]  SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  state_t      state, state_next;
  logic [7:0]  count, count_next;
  logic [9:0]  l_next, r_next, x_next, y_next;
  logic [3:0]  l_score_next, r_score_next;
  logic        dir_x, dir_y, dir_x_next, dir_y_next;
  logic        r_up_eff, r_down_eff;
  logic        hit_l, hit_r;
  logic [10:0] x_sum, y_sum, y_wide;

  function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic up,
                                             input logic down);
    logic [10:0] sum;
    sum = {1'b0, pos} + PSPEED;
    paddle_step = pos;
    if (up && !down)
      paddle_step = (pos >= PSPEED10) ? pos - PSPEED10 : 10'd0;
    else if (down && !up)
      paddle_step = (sum > 11'd450) ? 10'd450 : sum[9:0];
  endfunction

`ifdef PONG_AI_EN
  // Steer the right paddle so its centre chases the ball centre.
  logic [10:0] ball_mid, pad_mid;
  assign ball_mid   = {1'b0, y_ball_pos} + 11'd5;
  assign pad_mid    = {1'b0, r_pos} + 11'd75;
  assign r_up_eff   = ball_mid < pad_mid;
  assign r_down_eff = ball_mid > pad_mid;
`else
  assign r_up_eff   = r_up;
  assign r_down_eff = r_down;
`endif

  assign y_wide = {1'b0, y_ball_pos};
  assign x_sum  = {1'b0, x_ball_pos} + BSPEED;
  assign y_sum  = y_wide + BSPEED;
  assign hit_l  = (y_wide + 11'd10 > {1'b0, l_pos}) && (y_wide < {1'b0, l_pos} + 11'd150);
  assign hit_r  = (y_wide + 11'd10 > {1'b0, r_pos}) && (y_wide < {1'b0, r_pos} + 11'd150);
  assign game_over = (state == OVER);

  always_comb begin
    state_next   = state;
    count_next   = count;
    l_next       = l_pos;
    r_next       = r_pos;
    x_next       = x_ball_pos;
    y_next       = y_ball_pos;
    dir_x_next   = dir_x;
    dir_y_next   = dir_y;
    l_score_next = l_score;
    r_score_next = r_score;
    case (state)
      SERVE: begin
        l_next = paddle_step(l_pos, l_up, l_down);
        r_next = paddle_step(r_pos, r_up_eff, r_down_eff);
        x_next = 10'd395;
        y_next = 10'd295;
        if (count == 8'd1) begin
          count_next = SERVE_LOAD;
          state_next = PLAY;
        end else begin
          count_next = count - 8'd1;
        end
      end
      PLAY: begin
        l_next = paddle_step(l_pos, l_up, l_down);
        r_next = paddle_step(r_pos, r_up_eff, r_down_eff);
        if (dir_y) begin
          if (y_sum >= 11'd590) begin
            y_next     = 10'd590;
            dir_y_next = 1'b0;
          end else begin
            y_next = y_sum[9:0];
          end
        end else if (y_wide < BSPEED) begin
          y_next     = 10'd0;
          dir_y_next = 1'b1;
        end else begin
          y_next = y_ball_pos - BSPEED10;
        end
        // A miss recentres the ball and serves it toward the player who lost the point.
        if (!dir_x && ({1'b0, x_ball_pos} < 11'd20 + BSPEED)) begin
          if (hit_l) begin
            x_next     = 10'd20;
            dir_x_next = 1'b1;
          end else begin
            r_score_next = r_score + 4'd1;
            x_next       = 10'd395;
            y_next       = 10'd295;
            dir_x_next   = 1'b0;
            dir_y_next   = dir_y;
            state_next   = (r_score + 4'd1 == WIN) ? OVER : SERVE;
          end
        end else if (dir_x && (x_sum >= 11'd770)) begin
          if (hit_r) begin
            x_next     = 10'd770;
            dir_x_next = 1'b0;
          end else begin
            l_score_next = l_score + 4'd1;
            x_next       = 10'd395;
            y_next       = 10'd295;
            dir_x_next   = 1'b1;
            dir_y_next   = dir_y;
            state_next   = (l_score + 4'd1 == WIN) ? OVER : SERVE;
          end
        end else if (dir_x) begin
          x_next = x_sum[9:0];
        end else begin
          x_next = x_ball_pos - BSPEED10;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SERVE;
      count      <= SERVE_LOAD;
      l_pos      <= 10'd225;
      r_pos      <= 10'd225;
      x_ball_pos <= 10'd395;
      y_ball_pos <= 10'd295;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      l_score    <= 4'd0;
      r_score    <= 4'd0;
    end else if (frame_tick) begin
      state      <= state_next;
      count      <= count_next;
      l_pos      <= l_next;
      r_pos      <= r_next;
      x_ball_pos <= x_next;
      y_ball_pos <= y_next;
      dir_x      <= dir_x_next;
      dir_y      <= dir_y_next;
      l_score    <= l_score_next;
      r_score    <= r_score_next;
    end
  end

endmodule

// File: tb/tb_pong_game.sv
// Self-checking bench for pong_game: a behavioural game model feeds a scoreboard queue,
// plus directed constant checks for clamping, serve timing, wall bounce and paddle hits.
module tb_pong_game;

  localparam int PS  = 4;
  localparam int BS  = 3;
  localparam int SF  = 2;
  localparam int WIN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       l_up = 1'b0, l_down = 1'b0, r_up = 1'b0, r_down = 1'b0;
  logic [9:0] l_pos, r_pos, x_ball_pos, y_ball_pos;
  logic [3:0] l_score, r_score;
  logic       game_over;

  always #5 clk = ~clk;

  pong_game #(
    .PADDLE_SPEED(PS),
    .BALL_SPEED  (BS),
    .SERVE_FRAMES(SF),
    .WIN_SCORE   (WIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .l_up      (l_up),
    .l_down    (l_down),
    .r_up      (r_up),
    .r_down    (r_down),
    .l_pos     (l_pos),
    .r_pos     (r_pos),
    .x_ball_pos(x_ball_pos),
    .y_ball_pos(y_ball_pos),
    .l_score   (l_score),
    .r_score   (r_score),
    .game_over (game_over)
  );

  typedef struct {
    int l; int r; int x; int y; int ls; int rs; int go;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state; directions are +1/-1, m_st is 0 serve, 1 play, 2 over.
  int m_l, m_r, m_x, m_y, m_dx, m_dy, m_ls, m_rs, m_st, m_cnt;

  function automatic int movePaddle(input int pos, input bit up, input bit down);
    if (up && !down) return (pos - PS < 0) ? 0 : pos - PS;
    if (down && !up) return (pos + PS > 450) ? 450 : pos + PS;
    return pos;
  endfunction

  function automatic bit overlaps(input int by, input int py);
    return (by + 10 > py) && (by < py + 150);
  endfunction

  task automatic modelReset;
    m_l = 225; m_r = 225; m_x = 395; m_y = 295; m_dx = 1; m_dy = 1;
    m_ls = 0; m_rs = 0; m_st = 0; m_cnt = SF;
  endtask

  task automatic modelTick(input bit lu, input bit ld, input bit ru, input bit rd);
    int nl, nr, nx, ny, ndx, ndy;
    bit au, ad;
    if (m_st == 2) return;
    au = ru;
    ad = rd;
`ifdef PONG_AI_EN
    au = (m_y + 5 < m_r + 75);
    ad = (m_y + 5 > m_r + 75);
`endif
    nl = movePaddle(m_l, lu, ld);
    nr = movePaddle(m_r, au, ad);
    if (m_st == 0) begin
      if (m_cnt == 1) begin
        m_cnt = SF;
        m_st  = 1;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else begin
      ny  = m_y + m_dy * BS;
      ndy = m_dy;
      if (ny >= 590) begin
        ny = 590; ndy = -1;
      end else if (ny < 0) begin
        ny = 0; ndy = 1;
      end
      nx  = m_x + m_dx * BS;
      ndx = m_dx;
      if (m_dx < 0 && nx < 20) begin
        if (overlaps(m_y, m_l)) begin
          nx = 20; ndx = 1;
        end else begin
          m_rs = m_rs + 1;
          nx = 395; ny = 295; ndx = -1; ndy = m_dy;
          m_st = (m_rs == WIN) ? 2 : 0;
        end
      end else if (m_dx > 0 && nx >= 770) begin
        if (overlaps(m_y, m_r)) begin
          nx = 770; ndx = -1;
        end else begin
          m_ls = m_ls + 1;
          nx = 395; ny = 295; ndx = 1; ndy = m_dy;
          m_st = (m_ls == WIN) ? 2 : 0;
        end
      end
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
    m_l = nl;
    m_r = nr;
  endtask

  task automatic pushExpected;
    exp_t e;
    e.l = m_l; e.r = m_r; e.x = m_x; e.y = m_y;
    e.ls = m_ls; e.rs = m_rs; e.go = (m_st == 2) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput;
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    checkField("l_pos", l_pos, e.l);
    checkField("r_pos", r_pos, e.r);
    checkField("x_ball_pos", x_ball_pos, e.x);
    checkField("y_ball_pos", y_ball_pos, e.y);
    checkField("l_score", l_score, e.ls);
    checkField("r_score", r_score, e.rs);
    checkField("game_over", game_over, e.go);
  endtask

  task automatic applyStimulus(input bit lu, input bit ld, input bit ru, input bit rd,
                               input bit tick);
    @(negedge clk);
    l_up = lu; l_down = ld; r_up = ru; r_down = rd;
    frame_tick = tick;
    if (tick) modelTick(lu, ld, ru, rd);
    pushExpected();
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    checkOutput();
  endtask

  task automatic applyReset(input bit tick);
    @(negedge clk);
    reset = 1'b0;
    frame_tick = tick;
    l_up = 1'b1; r_down = 1'b1;
    modelReset();
    pushExpected();
    @(posedge clk);
    #1;
    reset = 1'b1;
    frame_tick = 1'b0;
    l_up = 1'b0; r_down = 1'b0;
    checkOutput();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);

    // Reset values, then hold with buttons toggling but no ticks.
    applyReset(1'b0);
    checkField("rst_l_pos", l_pos, 225);
    checkField("rst_r_pos", r_pos, 225);
    checkField("rst_x", x_ball_pos, 395);
    checkField("rst_y", y_ball_pos, 295);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    // Paddle stepping and clamping.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkField("l_first_up", l_pos, 221);
    repeat (59) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkField("l_clamp_top", l_pos, 0);
    applyReset(1'b0);
    repeat (60) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkField("l_clamp_bottom", l_pos, 450);
    checkField("r_clamp_top", r_pos, 0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkField("both_hold", l_pos, 450);

    // Serve timing with SF=2: ball moves on the third tick only.
    applyReset(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkField("serve_hold_x", x_ball_pos, 395);
    checkField("serve_hold_y", y_ball_pos, 295);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkField("first_move_x", x_ball_pos, 398);
    checkField("first_move_y", y_ball_pos, 298);

    // Bottom wall bounce then right paddle hit with r_pos parked at 450.
    applyReset(1'b0);
    for (int t = 1; t <= 130; t++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (t == 100) checkField("y_near_wall", y_ball_pos, 589);
      if (t == 101) checkField("y_at_wall", y_ball_pos, 590);
      if (t == 102) checkField("y_after_wall", y_ball_pos, 587);
      if (t == 127) checkField("x_right_hit", x_ball_pos, 770);
      if (t == 128) checkField("x_after_hit", x_ball_pos, 767);
    end

    // Reset coinciding with a tick mid-play wins.
    applyReset(1'b1);
    checkField("rst_tick_x", x_ball_pos, 395);
    checkField("rst_tick_r", r_pos, 225);

    // Free play with random buttons.
    for (int t = 0; t < 800; t++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);

    // Both paddles parked at the top until someone reaches WIN.
    applyReset(1'b0);
    n = 0;
    while (m_st != 2 && n < 3000) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    checkField("over_flag", game_over, 1);
    checkField("over_score", (l_score == 4'd2) || (r_score == 4'd2), 1);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    checkField("over_frozen", game_over, 1);

    applyReset(1'b0);
    checkField("final_rst_go", game_over, 0);
    checkField("final_rst_ls", l_score, 0);
    checkField("final_rst_rs", r_score, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game.md
# pong_game

Per-frame game-state engine for the pong design: owns paddle positions, ball position and direction, scores and serve/game-over sequencing. It sits directly upstream of the VGA renderer and drives its `l_pos`, `r_pos`, `x_ball_pos` and `y_ball_pos` inputs. All state advances once per `frame_tick`, a one-cycle pulse generated externally at the start of vertical sync, so positions never change mid-scan.

## Interface
- `PADDLE_SPEED`, 4, pixels a paddle moves per frame (1..20)
- `BALL_SPEED`, 3, pixels the ball moves per frame on each axis (1..10)
- `SERVE_FRAMES`, 60, frames the ball is held centred before each serve (1..255)
- `WIN_SCORE`, 9, score that ends the game (1..15)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse, one per frame
- `l_up`, `l_down`, `r_up`, `r_down`  in  1 each  paddle controls, synchronised and level-sensitive
- `l_pos`, `r_pos`  out  10  paddle top y, 0..450 (paddle is 150 tall)
- `x_ball_pos`, `y_ball_pos`  out  10  ball top-left corner, x 0..790, y 0..590 (ball is 10x10)
- `l_score`, `r_score`  out  4  points won by each player
- `game_over`  out  1  high while in OVER state

## Operation
- Playfield is 800x600. The left paddle occupies x 0..19 and the right paddle x 780..799.
- State machine with states SERVE, PLAY and OVER. All updates happen only on edges where `frame_tick`=1; otherwise every register holds.
- Reset values:
  - `l_pos` = `r_pos` = 225; ball (395,295), moving +x and +y.
  - Scores 0; `game_over`=0; state SERVE; serve counter = SERVE_FRAMES.
- Paddles, updated in SERVE and PLAY:
  - up without down: pos ← pos≥PADDLE_SPEED ? pos−PADDLE_SPEED : 0.
  - down without up: pos ← min(pos+PADDLE_SPEED, 450).
  - Both or neither pressed: hold.
- SERVE: the ball is held at (395,295) and the counter decrements each tick. A tick with counter==1 reloads the counter and enters PLAY. The ball does not move on that tick.
- PLAY, vertical:
  - Moving +y with y+BALL_SPEED≥590: y←590 and direction flips to −y.
  - Moving −y with y<BALL_SPEED: y←0 and direction flips to +y.
  - Otherwise y←y±BALL_SPEED.
- PLAY, horizontal:
  - Moving −x with x<20+BALL_SPEED: test for a hit against the left paddle.
  - Moving +x with x+BALL_SPEED≥770: test for a hit against the right paddle.
  - Otherwise x←x±BALL_SPEED.
  - Hit test uses the *pre-tick* paddle value and the *pre-tick* ball y: hit iff y+10>pos and y<pos+150.
- Hit: x←20 (left) or 770 (right) and x direction flips. The y update still applies on the same tick.
- Miss:
  - The opposite player's score increments and the ball recentres to (395,295).
  - The new x direction points toward the player who lost the point; y direction is kept.
  - Next state is SERVE, or OVER if the incremented score equals WIN_SCORE.
- OVER: everything frozen and `game_over`=1. Only `reset` leaves OVER.
- Arithmetic: 11-bit intermediates for all sums, so there is no wraparound. Scores never exceed WIN_SCORE.

## Timing
- All outputs are registered. Values change on the edge sampling `frame_tick`=1 and are visible the following cycle (latency 1).
- Back-to-back `frame_tick` pulses each count as a full frame; no minimum spacing.
- Button levels are sampled only on tick edges; presses between ticks are ignored.
- A `reset`=0 edge overrides a simultaneous `frame_tick`, and reset mid-serve or mid-play restores all reset values immediately.
- The corner case (wall bounce and paddle test on the same tick) applies both updates independently.

## Configuration
- `PONG_AI_EN` defined: `r_up`/`r_down` are ignored and the right paddle is driven internally.
  - Effective up when y_ball_pos+5 < r_pos+75.
  - Effective down when y_ball_pos+5 > r_pos+75.
  - Hold when equal.
  - Same speed and clamping rules as a human-driven paddle.
- Not defined: the right paddle follows `r_up`/`r_down` exactly like the left paddle.

## Test plan
- Reset release with no ticks → outputs 225, 225, 395, 295, scores 0, `game_over`=0, all holding indefinitely.
- Hold `l_up` for 60 ticks → `l_pos` steps 221, 217 … then clamps at 0. Hold `l_down` → clamps at 450. Both pressed → no change.
- SERVE_FRAMES=2: 2 ticks → still (395,295). Third tick → (398,298).
- Force the ball to (771,100) moving +x with `r_pos`=50 → one tick gives x=770 and direction −x. With `r_pos`=300 → `l_score`=1, ball (395,295), state SERVE, next serve moving +x.
- Ball at y=589 moving +y → y=590, then 587 on the following tick. Ball at y=2 moving −y → y=0, then 3.
- WIN_SCORE=1, right-side miss → `l_score`=1 and `game_over`=1. Further ticks and button presses change nothing. `reset`=0 for one cycle → all reset values.
- With `PONG_AI_EN`, ball y=500 and `r_pos`=0 → `r_pos` increments by 4 per tick regardless of `r_up`.
